// File: rtl/i2c_slave_regmap_if.sv
// Byte-level I2C slave handshake plus local host register port for i2c_slave_regmap.
// master drives the bus side (slave FSM + host); slave is the register-map controller.
interface i2c_slave_regmap_if #(parameter int ADDR_W = 4);
  logic              txn_start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              i2c_wr;
  logic [ADDR_W-1:0] i2c_wr_addr;
  logic              collision;

  modport master (
    output txn_start, rx_data, rx_valid, tx_done, host_we, host_addr, host_wdata,
    input  tx_data, host_rdata, i2c_wr, i2c_wr_addr, collision
  );

  modport slave (
    input  txn_start, rx_data, rx_valid, tx_done, host_we, host_addr, host_wdata,
    output tx_data, host_rdata, i2c_wr, i2c_wr_addr, collision
  );
endinterface

// File: rtl/i2c_slave_regmap.sv
// Register-file controller behind an I2C slave byte interface, shared with a host port.
// Optional I2C write protection per register is enabled by defining I2C_REGMAP_WPROT_EN.
module i2c_slave_regmap #(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef I2C_REGMAP_WPROT_EN
  input  logic [(2**ADDR_W)-1:0] wprot,
`endif
  i2c_slave_regmap_if.slave      bus
);
  localparam int REG_COUNT = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, PTR, WRITE, READ} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              rx_valid_d_reg;
  logic              tx_done_d_reg;
  logic [7:0]        regs [REG_COUNT];

  logic rx_edge;
  logic tx_edge;
  logic wr_blocked;
  logic i2c_we;

  // rx_valid / tx_done are levels from the slave; only their rising edge is a byte event.
  assign rx_edge = bus.rx_valid & ~rx_valid_d_reg;
  assign tx_edge = bus.tx_done  & ~tx_done_d_reg;

`ifdef I2C_REGMAP_WPROT_EN
  assign wr_blocked = wprot[ptr_reg];
`else
  assign wr_blocked = 1'b0;
`endif

  assign i2c_we = ~bus.txn_start & rx_edge & (state_reg == WRITE) & ~wr_blocked;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      rx_valid_d_reg  <= 1'b0;
      tx_done_d_reg   <= 1'b0;
      bus.i2c_wr      <= 1'b0;
      bus.i2c_wr_addr <= '0;
      bus.collision   <= 1'b0;
    end else begin
      rx_valid_d_reg <= bus.rx_valid;
      tx_done_d_reg  <= bus.tx_done;
      bus.i2c_wr     <= i2c_we;
      bus.collision  <= i2c_we & bus.host_we & (bus.host_addr == ptr_reg);
      if (i2c_we) begin
        bus.i2c_wr_addr <= ptr_reg;
      end
      // A (re)START always wins over a byte event arriving in the same cycle.
      if (bus.txn_start) begin
        state_reg <= PTR;
      end else begin
        case (state_reg)
          PTR: begin
            if (rx_edge) begin
              ptr_reg   <= bus.rx_data[ADDR_W-1:0];
              state_reg <= WRITE;
            end else if (tx_edge) begin
              ptr_reg   <= ptr_reg + ADDR_W'(1);
              state_reg <= READ;
            end
          end
          WRITE: begin
            if (rx_edge) begin
              ptr_reg <= ptr_reg + ADDR_W'(1);
            end else if (tx_edge) begin
              ptr_reg   <= ptr_reg + ADDR_W'(1);
              state_reg <= READ;
            end
          end
          READ: begin
            if (tx_edge) begin
              ptr_reg <= ptr_reg + ADDR_W'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Host write has priority over an I2C write to the same register.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          regs[gi] <= 8'h00;
        end else if (bus.host_we && (bus.host_addr == ADDR_W'(gi))) begin
          regs[gi] <= bus.host_wdata;
        end else if (i2c_we && (ptr_reg == ADDR_W'(gi))) begin
          regs[gi] <= bus.rx_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.tx_data    <= 8'h00;
      bus.host_rdata <= 8'h00;
    end else begin
      bus.tx_data    <= regs[ptr_reg];
      bus.host_rdata <= regs[bus.host_addr];
    end
  end
endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Scoreboard bench for i2c_slave_regmap: expected I2C register writes are queued at stimulus
// time and retired by a monitor on each i2c_wr pulse; register contents checked via host port.
module tb_i2c_slave_regmap;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
`ifdef I2C_REGMAP_WPROT_EN
  logic [(2**ADDR_W)-1:0] wprot = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];

  i2c_slave_regmap_if #(.ADDR_W(ADDR_W)) bus ();

  i2c_slave_regmap #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef I2C_REGMAP_WPROT_EN
    .wprot (wprot),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Scoreboard monitor: every i2c_wr pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.i2c_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL i2c_wr_unexpected: got addr %h required no write", bus.i2c_wr_addr);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.i2c_wr_addr !== e) begin
          errors++;
          $display("FAIL i2c_wr_addr: got %h required %h", bus.i2c_wr_addr, e);
        end else begin
          $display("i2c write retired addr %h", e);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); bus.txn_start = 1'b1;
    @(negedge clk); bus.txn_start = 1'b0;
    $display("txn_start");
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk); bus.rx_data = b; bus.rx_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.rx_valid = 1'b0;
    $display("rx byte %h", b);
  endtask

  task automatic tx_pulse();
    @(negedge clk); bus.tx_done = 1'b1;
    @(negedge clk); bus.tx_done = 1'b0;
    @(negedge clk);
    $display("tx byte done");
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk); bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    @(negedge clk); bus.host_we = 1'b0;
    $display("host write reg%0d = %h", a, d);
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    @(negedge clk); bus.host_addr = a;
    @(negedge clk); d = bus.host_rdata;
    $display("host read reg%0d = %h", a, d);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.tx_data !== 8'h00 || bus.host_rdata !== 8'h00 || bus.i2c_wr !== 1'b0 ||
        bus.i2c_wr_addr !== 4'h0 || bus.collision !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tx %h rd %h wr %b wa %h col %b required all 0",
               bus.tx_data, bus.host_rdata, bus.i2c_wr, bus.i2c_wr_addr, bus.collision);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] d;
    pulse_start();
    send_rx(8'h03);
    exp_q.push_back(4'd3); send_rx(8'hAA);
    exp_q.push_back(4'd4); send_rx(8'hBB);
    host_read(4'd3, d);
    checks++;
    if (d !== 8'hAA) begin errors++; $display("FAIL burst_reg3: got %h required aa", d); end
    host_read(4'd4, d);
    checks++;
    if (d !== 8'hBB) begin errors++; $display("FAIL burst_reg4: got %h required bb", d); end
  endtask

  task automatic test_read_restart();
    host_write(4'd5, 8'h5C);
    pulse_start();
    send_rx(8'h03);
    pulse_start();
    checks++;
    if (bus.tx_data !== 8'hAA) begin
      errors++; $display("FAIL read_byte0: got %h required aa", bus.tx_data);
    end
    tx_pulse();
    checks++;
    if (bus.tx_data !== 8'hBB) begin
      errors++; $display("FAIL read_byte1: got %h required bb", bus.tx_data);
    end
    tx_pulse();
    checks++;
    if (bus.tx_data !== 8'h5C) begin
      errors++; $display("FAIL read_byte2: got %h required 5c", bus.tx_data);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    host_write(4'd1, 8'h77);
    pulse_start();
    send_rx(8'hFF);
    exp_q.push_back(4'd15); send_rx(8'h11);
    exp_q.push_back(4'd0);  send_rx(8'h22);
    host_read(4'd15, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL wrap_reg15: got %h required 11", d); end
    host_read(4'd0, d);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL wrap_reg0: got %h required 22", d); end
    pulse_start();
    @(negedge clk);
    checks++;
    if (bus.tx_data !== 8'h77) begin
      errors++; $display("FAIL wrap_ptr: got tx %h required 77 (ptr 1)", bus.tx_data);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    pulse_start();
    send_rx(8'h04);
    exp_q.push_back(4'd4);
    @(negedge clk);
    bus.rx_data = 8'h99; bus.rx_valid = 1'b1;
    bus.host_we = 1'b1; bus.host_addr = 4'd4; bus.host_wdata = 8'h55;
    @(negedge clk); bus.host_we = 1'b0;
    checks++;
    if (bus.collision !== 1'b1) begin
      errors++; $display("FAIL collision_pulse: got %b required 1", bus.collision);
    end
    @(negedge clk); bus.rx_valid = 1'b0;
    checks++;
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL collision_width: got %b required 0", bus.collision);
    end
    host_read(4'd4, d);
    checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL collision_reg4: got %h required 55", d); end
    // Different addresses in the same cycle: both writes commit, no collision.
    exp_q.push_back(4'd5);
    @(negedge clk);
    bus.rx_data = 8'h66; bus.rx_valid = 1'b1;
    bus.host_we = 1'b1; bus.host_addr = 4'd6; bus.host_wdata = 8'h77;
    @(negedge clk); bus.host_we = 1'b0;
    checks++;
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL no_collision: got %b required 0", bus.collision);
    end
    @(negedge clk); bus.rx_valid = 1'b0;
    host_read(4'd5, d);
    checks++;
    if (d !== 8'h66) begin errors++; $display("FAIL both_reg5: got %h required 66", d); end
    host_read(4'd6, d);
    checks++;
    if (d !== 8'h77) begin errors++; $display("FAIL both_reg6: got %h required 77", d); end
  endtask

  task automatic test_held_rx();
    logic [7:0] d;
    pulse_start();
    send_rx(8'h08);
    exp_q.push_back(4'd8);
    @(negedge clk); bus.rx_data = 8'h3C; bus.rx_valid = 1'b1;
    repeat (20) @(negedge clk);
    bus.rx_valid = 1'b0;
    $display("rx byte 3c held 20 cycles");
    host_read(4'd8, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL held_reg8: got %h required 3c", d); end
    host_read(4'd9, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL held_reg9: got %h required 00", d); end
  endtask

  task automatic test_start_coincident();
    logic [7:0] d;
    host_write(4'd9, 8'hA5);
    @(negedge clk);
    bus.txn_start = 1'b1; bus.rx_data = 8'h10; bus.rx_valid = 1'b1;
    @(negedge clk); bus.txn_start = 1'b0;
    @(negedge clk); bus.rx_valid = 1'b0;
    $display("txn_start with rx byte 10");
    checks++;
    if (bus.tx_data !== 8'hA5) begin
      errors++; $display("FAIL coincident_ptr: got tx %h required a5 (ptr 9)", bus.tx_data);
    end
    send_rx(8'h02);
    exp_q.push_back(4'd2); send_rx(8'h44);
    host_read(4'd2, d);
    checks++;
    if (d !== 8'h44) begin errors++; $display("FAIL coincident_reg2: got %h required 44", d); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    pulse_start();
    send_rx(8'h0A);
    exp_q.push_back(4'd10); send_rx(8'hEE);
    @(negedge clk); bus.host_addr = 4'd10;
    @(negedge clk);
    checks++;
    if (bus.host_rdata !== 8'hEE) begin
      errors++; $display("FAIL pre_reset_rd: got %h required ee", bus.host_rdata);
    end
    #2 reset = 1'b0;
    #1;
    $display("async reset asserted");
    checks++;
    if (bus.tx_data !== 8'h00 || bus.host_rdata !== 8'h00 || bus.i2c_wr !== 1'b0 ||
        bus.i2c_wr_addr !== 4'h0 || bus.collision !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got tx %h rd %h wr %b wa %h col %b required all 0",
               bus.tx_data, bus.host_rdata, bus.i2c_wr, bus.i2c_wr_addr, bus.collision);
    end
    @(negedge clk); reset = 1'b1;
    send_rx(8'h33);
    send_rx(8'h44);
    host_read(4'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_reg0: got %h required 00", d); end
    host_read(4'd3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_reg3: got %h required 00", d); end
  endtask

`ifdef I2C_REGMAP_WPROT_EN
  task automatic test_wprot();
    logic [7:0] d;
    wprot = 16'h0004;
    pulse_start();
    send_rx(8'h02);
    send_rx(8'h5A);
    exp_q.push_back(4'd3); send_rx(8'h6B);
    host_read(4'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL wprot_reg2: got %h required 00", d); end
    host_read(4'd3, d);
    checks++;
    if (d !== 8'h6B) begin errors++; $display("FAIL wprot_reg3: got %h required 6b", d); end
    host_write(4'd2, 8'h12);
    host_read(4'd2, d);
    checks++;
    if (d !== 8'h12) begin errors++; $display("FAIL wprot_host: got %h required 12", d); end
  endtask
`endif

  initial begin
    bus.txn_start = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_done = 1'b0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_write_burst();
    test_read_restart();
    test_wrap();
    test_collision();
    test_held_rx();
    test_start_coincident();
    test_async_reset();
`ifdef I2C_REGMAP_WPROT_EN
    test_wprot();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
